// File: rtl/avmm_pkg.sv
// Shared definitions for the Avalon-MM hex master.
//   state_e : FSM state encoding used by avmm_hex_master
//   BE_ALL  : full-word byte enable driven on every access
package avmm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    WRITE     = 3'd2,
    READ      = 3'd3,
    CHECK     = 3'd4
  } state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/avmm_hex_master_tick_gen.sv
// Period tick generator.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   clr     : synchronous clear; holds the counter at 0 while high
//   tick    : high in the cycle the counter holds PERIOD-1 (and clr is low)
module tick_gen #(
  parameter int unsigned PERIOD = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  // PERIOD=1 would give a zero-width counter; keep at least one bit.
  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avmm_hex_master.sv
// Avalon-MM master that periodically writes an incrementing 16-bit counter
// to one slave register, reads it back and counts readback mismatches.
//   clk, reset_n      : clock (rising edge), asynchronous active-low reset
//   enable            : run while high; an in-flight transaction always completes
//   avm_*             : Avalon-MM master port (single word address, full byte enable)
//   count             : last value committed to the slave
//   err_count         : saturating readback-mismatch counter
//   busy              : high during WRITE, READ and CHECK
module avmm_hex_master
  import avmm_pkg::*;
#(
  parameter int unsigned PERIOD      = 50000000,
  parameter int unsigned TARGET_ADDR = 0,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [15:0]       count,
  output logic [7:0]        err_count,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] TGT = ADDR_W'(TARGET_ADDR);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] next_count;
  logic        tick_clr;
  logic        tick;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^avm_readdata[31:16];

  // The tick counter only runs in WAIT_TICK, so it restarts from 0 on
  // every entry into that state.
  tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tick_clr),
    .tick    (tick)
  );

  assign next_count     = count_q + 16'd1;
  assign count          = count_q;
  assign err_count      = err_q;
  assign avm_byteenable = BE_ALL;
  assign busy           = (state_q == WRITE) || (state_q == READ) || (state_q == CHECK);

  // Bus outputs decode straight from the state register so that an
  // asynchronous reset removes a pending request without a clock edge.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    tick_clr      = 1'b1;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        tick_clr = 1'b0;
        if (!enable)   state_d = IDLE;
        else if (tick) state_d = WRITE;
      end
      WRITE: begin
        avm_write     = 1'b1;
        avm_address   = TGT;
        avm_writedata = {16'h0000, next_count};
        if (!avm_waitrequest) state_d = READ;
      end
      READ: begin
        avm_read    = 1'b1;
        avm_address = TGT;
        if (!avm_waitrequest) begin
          rdata_d = avm_readdata[15:0];
          state_d = CHECK;
        end
      end
      CHECK: begin
        count_d = next_count;
        if ((rdata_q != next_count) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        state_d = enable ? WAIT_TICK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
